// File: rtl/act_skew_feeder.sv
// Activation skew feeder: delays row r of each accepted vector by r advance steps
// so diagonal wavefronts enter the systolic array, then zero-flushes the array after the tile.
module act_skew_feeder #(
  parameter int ROWS       = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DRAIN_LEN  = 15,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] s_data,
  input  logic                       s_last,
  output logic [ROWS*DATA_WIDTH-1:0] out_act,
  output logic                       en_compute,
  output logic                       busy,
  output logic                       done,
  output logic [CNT_WIDTH-1:0]       beat_cnt
);

  localparam int LEFT_W = $clog2(DRAIN_LEN + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  logic [LEFT_W-1:0] drain_left;
  logic              accept;
  logic              advance;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign s_ready = (state != DRAIN);
  assign accept  = s_valid & s_ready;
  assign advance = accept | (state == DRAIN);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      drain_left <= '0;
      done       <= 1'b0;
      en_compute <= 1'b0;
      beat_cnt   <= '0;
    end else begin
      done       <= 1'b0;
      en_compute <= advance;
      // First accept of a tile restarts the count; the skew chains are already zero here.
      if (accept)
        beat_cnt <= (state == IDLE) ? CNT_WIDTH'(1) : sat_inc(beat_cnt);
      case (state)
        IDLE, FEED: begin
          if (accept) begin
            if (s_last) begin
              state      <= DRAIN;
              drain_left <= LEFT_W'(DRAIN_LEN);
            end else begin
              state <= FEED;
            end
          end
        end
        DRAIN: begin
          if (drain_left == LEFT_W'(1)) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            drain_left <= drain_left - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic signed [DATA_WIDTH-1:0] skew_p [r+1];
    logic signed [DATA_WIDTH-1:0] stage_in;

    // Drain injects zeros so every partial sum is pushed out of the array.
    assign stage_in = (state == DRAIN) ? '0 : s_data[r*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k <= r; k++) skew_p[k] <= '0;
      end else if (advance) begin
        skew_p[0] <= stage_in;
        for (int k = 1; k <= r; k++) skew_p[k] <= skew_p[k-1];
      end
    end

    assign out_act[r*DATA_WIDTH +: DATA_WIDTH] = skew_p[r];
  end

endmodule

// File: tb/tb_act_skew_feeder.sv
// Bench for act_skew_feeder: directed scenarios plus randomized traffic checked
// against a vector-history model of the skewed output.
module tb_act_skew_feeder;
  localparam int ROWS  = 8;
  localparam int DW    = 8;
  localparam int DRAIN = 15;
  localparam int CW    = 4;
  localparam int VW    = ROWS * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic [VW-1:0] s_data = '0;
  logic          s_ready;
  logic [VW-1:0] out_act;
  logic          en_compute, busy, done;
  logic [CW-1:0] beat_cnt;

  act_skew_feeder #(.ROWS(ROWS), .DATA_WIDTH(DW), .DRAIN_LEN(DRAIN), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .out_act(out_act), .en_compute(en_compute), .busy(busy),
    .done(done), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: 0 idle, 1 feed, 2 drain; hist holds every vector that entered the chains.
  int            m_state, m_left, m_beat;
  bit            m_en, m_done, obs_rdy, exp_rdy;
  logic [VW-1:0] hist[$];

  function automatic logic [VW-1:0] exp_act();
    logic [VW-1:0] e, h;
    e = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (hist.size() > r) begin
        h = hist[hist.size()-1-r];
        e[r*DW +: DW] = h[r*DW +: DW];
      end
    end
    return e;
  endfunction

  function automatic logic [VW-1:0] mkvec(input int base);
    logic [VW-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r*DW +: DW] = DW'(base + r);
    return v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_left = 0; m_beat = 0; m_en = 0; m_done = 0;
    hist.delete();
  endtask

  task automatic cycle(input logic v, input logic l, input logic [VW-1:0] d);
    bit acc, adv;
    @(negedge clk);
    s_valid = v; s_last = l; s_data = d;
    #1;
    obs_rdy = s_ready;
    exp_rdy = (m_state != 2);
    acc = v && (m_state != 2);
    adv = acc || (m_state == 2);
    @(posedge clk);
    #1;
    m_done = 0;
    if (adv) begin
      hist.push_back(acc ? d : '0);
      if (hist.size() > ROWS) void'(hist.pop_front());
    end
    if (acc) m_beat = (m_state == 0) ? 1 : ((m_beat == (1 << CW) - 1) ? m_beat : m_beat + 1);
    if (m_state == 2) begin
      if (m_left == 1) begin m_done = 1; m_state = 0; end
      else m_left--;
    end else if (acc) begin
      if (l) begin m_state = 2; m_left = DRAIN; end
      else m_state = 1;
    end
    m_en = adv;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++; if (out_act !== '0) begin errors++; $display("FAIL reset_act got %h want 0", out_act); end
    checks++; if (en_compute !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", en_compute); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", s_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (beat_cnt !== '0) begin errors++; $display("FAIL reset_beat got %0d want 0", beat_cnt); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] e;
    cycle(1, 0, mkvec(1));
    e = '0; e[7:0] = 8'd1;
    checks++; if (out_act !== e) begin errors++; $display("FAIL b2b_first act %h want %h", out_act, e); end
    checks++; if (en_compute !== 1'b1) begin errors++; $display("FAIL b2b_first_en got %b want 1", en_compute); end
    cycle(1, 0, mkvec(11));
    cycle(1, 1, mkvec(21));
    e = '0; e[7:0] = 8'd21; e[15:8] = 8'd12; e[23:16] = 8'd3;
    checks++; if (out_act !== e) begin errors++; $display("FAIL b2b_third act %h want %h", out_act, e); end
    checks++; if (beat_cnt !== CW'(3)) begin errors++; $display("FAIL b2b_beat got %0d want 3", beat_cnt); end
    for (int i = 0; i < DRAIN; i++) begin
      cycle(0, 0, '0);
      checks++; if (en_compute !== 1'b1) begin errors++; $display("FAIL b2b_drain_en[%0d] got %b want 1", i, en_compute); end
      checks++; if (done !== (i == DRAIN - 1)) begin errors++; $display("FAIL b2b_done[%0d] got %b want %b", i, done, i == DRAIN - 1); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle busy %b want 0", busy); end
    checks++; if (beat_cnt !== CW'(3)) begin errors++; $display("FAIL b2b_beat_hold got %0d want 3", beat_cnt); end
    checks++; if (out_act !== '0) begin errors++; $display("FAIL b2b_flushed act %h want 0", out_act); end
  endtask

  task automatic test_stall();
    logic [VW-1:0] snap;
    cycle(1, 0, mkvec(1));
    snap = out_act;
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, mkvec(99));
      checks++; if (en_compute !== 1'b0) begin errors++; $display("FAIL stall_en[%0d] got %b want 0", i, en_compute); end
      checks++; if (out_act !== snap) begin errors++; $display("FAIL stall_frozen[%0d] act %h want %h", i, out_act, snap); end
    end
    cycle(1, 0, mkvec(11));
    checks++; if (out_act[15:8] !== 8'd2) begin errors++; $display("FAIL stall_row1 got %0d want 2", out_act[15:8]); end
    checks++; if (out_act[7:0] !== 8'd11) begin errors++; $display("FAIL stall_row0 got %0d want 11", out_act[7:0]); end
    checks++; if (en_compute !== 1'b1) begin errors++; $display("FAIL stall_resume_en got %b want 1", en_compute); end
    cycle(1, 1, mkvec(21));
    repeat (DRAIN) cycle(0, 0, '0);
  endtask

  task automatic test_single();
    cycle(1, 1, mkvec(1));
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL single_ready got %b want 0", s_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
    checks++; if (beat_cnt !== CW'(1)) begin errors++; $display("FAIL single_beat got %0d want 1", beat_cnt); end
    for (int i = 0; i < DRAIN; i++) begin
      cycle(0, 0, '0);
      if (i == 5) begin
        checks++; if (out_act[63:56] !== 8'd0) begin errors++; $display("FAIL single_row7_early got %0d want 0", out_act[63:56]); end
      end
      if (i == 6) begin
        checks++; if (out_act[63:56] !== 8'd8) begin errors++; $display("FAIL single_row7 got %0d want 8", out_act[63:56]); end
      end
      checks++; if (s_ready !== (i == DRAIN - 1)) begin errors++; $display("FAIL single_drain_ready[%0d] got %b want %b", i, s_ready, i == DRAIN - 1); end
      checks++; if (done !== (i == DRAIN - 1)) begin errors++; $display("FAIL single_done[%0d] got %b want %b", i, done, i == DRAIN - 1); end
    end
  endtask

  task automatic test_reset_mid_drain();
    cycle(1, 1, mkvec(31));
    repeat (5) cycle(0, 0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (out_act !== '0) begin errors++; $display("FAIL midrst_act got %h want 0", out_act); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", s_ready); end
    checks++; if (beat_cnt !== '0) begin errors++; $display("FAIL midrst_beat got %0d want 0", beat_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DRAIN + 3; i++) begin
      cycle(0, 0, '0);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_nodone[%0d] got %b want 0", i, done); end
    end
    test_back_to_back();
  endtask

  task automatic test_valid_in_drain();
    cycle(1, 0, mkvec(1));
    cycle(1, 1, mkvec(11));
    for (int i = 0; i < DRAIN; i++) begin
      cycle(1, 0, mkvec(21));
      checks++; if (beat_cnt !== CW'(2)) begin errors++; $display("FAIL vdrain_beat[%0d] got %0d want 2", i, beat_cnt); end
      checks++; if (done !== (i == DRAIN - 1)) begin errors++; $display("FAIL vdrain_done[%0d] got %b want %b", i, done, i == DRAIN - 1); end
    end
    cycle(1, 0, mkvec(21));
    checks++; if (beat_cnt !== CW'(1)) begin errors++; $display("FAIL vdrain_reload got %0d want 1", beat_cnt); end
    checks++; if (out_act[7:0] !== 8'd21) begin errors++; $display("FAIL vdrain_row0 got %0d want 21", out_act[7:0]); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL vdrain_busy got %b want 1", busy); end
    cycle(1, 1, mkvec(41));
    repeat (DRAIN) cycle(0, 0, '0);
  endtask

  task automatic test_random();
    logic v, l;
    for (int n = 0; n < 500; n++) begin
      v = ($urandom % 4) != 0;
      l = ($urandom % 30) == 0;
      cycle(v, l, {$urandom, $urandom});
      checks++; if (out_act !== exp_act()) begin errors++; $display("FAIL rnd_act[%0d] got %h want %h", n, out_act, exp_act()); end
      checks++; if (en_compute !== m_en) begin errors++; $display("FAIL rnd_en[%0d] got %b want %b", n, en_compute, m_en); end
      checks++; if (done !== m_done) begin errors++; $display("FAIL rnd_done[%0d] got %b want %b", n, done, m_done); end
      checks++; if (busy !== (m_state != 0)) begin errors++; $display("FAIL rnd_busy[%0d] got %b want %b", n, busy, m_state != 0); end
      checks++; if (beat_cnt !== CW'(m_beat)) begin errors++; $display("FAIL rnd_beat[%0d] got %0d want %0d", n, beat_cnt, m_beat); end
      checks++; if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL rnd_ready[%0d] got %b want %b", n, obs_rdy, exp_rdy); end
    end
    for (int n = 0; n < DRAIN + 2; n++) begin
      cycle(0, 0, '0);
      checks++; if (done !== m_done) begin errors++; $display("FAIL rnd_tail_done[%0d] got %b want %b", n, done, m_done); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    test_reset();
    test_back_to_back();
    test_stall();
    test_single();
    test_reset_mid_drain();
    test_valid_in_drain();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
